// File: rtl/sr_hazard_ctrl_if.sv
// Decode/execute/writeback side-band bundle of the issue/hazard scheduler.
// master = pipeline side driving decode/branch/retire info,
// slave  = the scheduler producing issue, stall and redirect controls.
interface sr_hazard_ctrl_if #(
  parameter int STALL_W = 16
);
  logic               dec_vld;
  logic [4:0]         dec_rs1;
  logic [4:0]         dec_rs2;
  logic               dec_use_rs1;
  logic               dec_use_rs2;
  logic [4:0]         dec_rd;
  logic               dec_reg_write;
  logic               dec_branch;
  logic               ex_br_vld;
  logic               ex_br_taken;
  logic [31:0]        ex_br_target;
  logic               wb_vld;
  logic [4:0]         wb_rd;
  logic               wb_reg_write;
  logic               issue_vld;
  logic               fetch_stall;
  logic               flush;
  logic               pc_load;
  logic [31:0]        pc_target;
  logic [31:0]        busy_mask;
  logic [STALL_W-1:0] stall_cnt;
  logic               sb_err;

  modport master (
    output dec_vld, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_reg_write, dec_branch, ex_br_vld, ex_br_taken, ex_br_target,
           wb_vld, wb_rd, wb_reg_write,
    input  issue_vld, fetch_stall, flush, pc_load, pc_target, busy_mask,
           stall_cnt, sb_err
  );

  modport slave (
    input  dec_vld, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_reg_write, dec_branch, ex_br_vld, ex_br_taken, ex_br_target,
           wb_vld, wb_rd, wb_reg_write,
    output issue_vld, fetch_stall, flush, pc_load, pc_target, busy_mask,
           stall_cnt, sb_err
  );
endinterface

// File: rtl/sr_hazard_ctrl.sv
// Issue/hazard scheduler for an in-order 5-stage pipeline.
// Per-register in-flight write counters stall decode on RAW/WAW hazards;
// a small FSM freezes fetch while a branch is unresolved and issues a
// one-cycle PC redirect plus decode flush when the branch is taken.
module sr_hazard_ctrl #(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  sr_hazard_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_REDIR   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q [32];
  logic [CNT_W-1:0]   cnt_d [32];
  logic               flush_q;
  logic               pc_load_q;
  logic [31:0]        pc_target_q;
  logic [STALL_W-1:0] stall_cnt_q;
  logic               sb_err_q;

  logic hazard;
  logic issue_vld;
  logic fetch_stall;
  logic inc_en;
  logic dec_en;
  logic retire_err;
  logic br_err;

  // Hazard detection against the pre-update scoreboard (no same-cycle bypass).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hazard = 1'b0;
    if (bus.dec_vld) begin
      if (bus.dec_use_rs1 && (bus.dec_rs1 != 5'd0) && (cnt_q[bus.dec_rs1] != '0))
        hazard = 1'b1;
      if (bus.dec_use_rs2 && (bus.dec_rs2 != 5'd0) && (cnt_q[bus.dec_rs2] != '0))
        hazard = 1'b1;
      if (bus.dec_reg_write && (bus.dec_rd != 5'd0) && (cnt_q[bus.dec_rd] == CNT_MAX))
        hazard = 1'b1;
    end
  end

  // Combinational issue/stall decision for the current state.
  always_comb begin
    issue_vld   = 1'b0;
    fetch_stall = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        issue_vld   = bus.dec_vld & ~hazard;
        fetch_stall = hazard;
      end
      ST_BR_WAIT: begin
        issue_vld   = 1'b0;
        fetch_stall = 1'b1;
      end
      ST_REDIR: begin
        issue_vld   = 1'b0;
        fetch_stall = 1'b0;
      end
      default: begin
        issue_vld   = 1'b0;
        fetch_stall = 1'b0;
      end
    endcase
  end

  // Scoreboard next-state: issue increments, retire decrements, both cancel.
  always_comb begin
    inc_en     = issue_vld & bus.dec_reg_write & (bus.dec_rd != 5'd0);
    dec_en     = bus.wb_vld & bus.wb_reg_write & (bus.wb_rd != 5'd0);
    retire_err = dec_en & (cnt_q[bus.wb_rd] == '0);
    br_err     = bus.ex_br_vld & (state_q != ST_BR_WAIT);
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 1; i < 32; i++) begin
      if (inc_en && (bus.dec_rd == 5'(i)) && !(dec_en && (bus.wb_rd == 5'(i))))
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (dec_en && (bus.wb_rd == 5'(i)) && !(inc_en && (bus.dec_rd == 5'(i)))
               && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - CNT_ONE;
    end
  end

  // Scoreboard counter storage; reset discards all in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the counter array is reset explicitly because a reset must forget in-flight writes; it is small enough to live in flops.
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Branch FSM with registered redirect outputs, stall counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_q     <= 1'b0;
      pc_load_q   <= 1'b0;
      pc_target_q <= 32'h0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      if (fetch_stall && (stall_cnt_q != STALL_MAX))
        stall_cnt_q <= stall_cnt_q + STALL_ONE;
      if (retire_err || br_err)
        sb_err_q <= 1'b1;
      unique case (state_q)
        ST_RUN: begin
          flush_q   <= 1'b0;
          pc_load_q <= 1'b0;
          if (issue_vld && bus.dec_branch)
            state_q <= ST_BR_WAIT;
        end
        ST_BR_WAIT: begin
          if (bus.ex_br_vld) begin
            if (bus.ex_br_taken) begin
              state_q     <= ST_REDIR;
              pc_target_q <= bus.ex_br_target;
              flush_q     <= 1'b1;
              pc_load_q   <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_REDIR: begin
          state_q   <= ST_RUN;
          flush_q   <= 1'b0;
          pc_load_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_RUN;
          flush_q   <= 1'b0;
          pc_load_q <= 1'b0;
        end
      endcase
    end
  end

  // Busy mask mirrors non-zero counters; x0 is never reported busy.
  always_comb begin
    bus.busy_mask = 32'h0;
    for (int i = 1; i < 32; i++) begin
      bus.busy_mask[i] = (cnt_q[i] != '0);
    end
  end

  assign bus.issue_vld   = issue_vld;
  assign bus.fetch_stall = fetch_stall;
  assign bus.flush       = flush_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_target   = pc_target_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.sb_err      = sb_err_q;

endmodule
